// File: rtl/hyper_exit_seq_if.sv
// Bus bundle between the hypervisor/CPU side and the exit sequencer.
// The sequencer is the slave; the CPU/hypervisor side is the master.
interface hyper_exit_seq_if;
  // Handshake and CPU bus
  logic        exit_req;
  logic        ready;
  logic        cpu_sync;
  logic [7:0]  cpu_ext_data_i;
  logic [7:0]  cpu_data_i;
  logic        inject_active;
  // Saved guest state captured at hypervisor entry
  logic [15:0] saved_pc;
  logic [7:0]  saved_p;
  logic [11:0] saved_map_off0;
  logic [11:0] saved_map_off1;
  logic [7:0]  saved_map_en;
  // Mapper path
  logic        map_gate;
  logic        map_enable;
  logic        mapper_wr;
  logic [1:0]  mapper_sel;
  logic [7:0]  mapper_wdata;
  // Status
  logic        exit_done;
  logic        busy;

  modport master (
    output exit_req, ready, cpu_sync, cpu_ext_data_i,
    output saved_pc, saved_p, saved_map_off0, saved_map_off1, saved_map_en,
    output map_gate,
    input  cpu_data_i, inject_active, map_enable,
    input  mapper_wr, mapper_sel, mapper_wdata,
    input  exit_done, busy
  );

  modport slave (
    input  exit_req, ready, cpu_sync, cpu_ext_data_i,
    input  saved_pc, saved_p, saved_map_off0, saved_map_off1, saved_map_en,
    input  map_gate,
    output cpu_data_i, inject_active, map_enable,
    output mapper_wr, mapper_sel, mapper_wdata,
    output exit_done, busy
  );
endinterface

// File: rtl/hyper_exit_seq.sv
// Hypervisor exit sequencer: injects CLE/SEE, PLP, JMP onto the CPU
// data-in bus to restore guest E, P and PC, and replays the saved guest
// MAP A/X/Y/Z registers into the mapper during the PLP/JMP fetches.
module hyper_exit_seq #(
  parameter logic [7:0] OP_CLE = 8'h02,
  parameter logic [7:0] OP_SEE = 8'h03,
  parameter logic [7:0] OP_PLP = 8'h28,
  parameter logic [7:0] OP_JMP = 8'h4C
) (
  input logic             clk,
  input logic             reset,
  hyper_exit_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CS_FETCH  = 4'd1,
    CS_EX     = 4'd2,
    PLP_FETCH = 4'd3,
    PLP_DEC   = 4'd4,
    PLP_EX    = 4'd5,
    JMP_FETCH = 4'd6,
    JMP_PCL   = 4'd7,
    JMP_PCH   = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  w_byte;
  logic [7:0]  w_cs_byte;
  logic        w_fetch_ok;
  logic        w_wr;
  logic [1:0]  w_sel;
  logic [7:0]  w_wdata;
  logic        w_done;
  logic        w_busy;

  assign w_cs_byte  = bus.saved_p[5] ? OP_SEE : OP_CLE;
  assign w_fetch_ok = bus.ready & bus.cpu_sync;
  assign w_busy     = (r_state != IDLE);

  // State register; reset returns to IDLE and drops any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state, injected byte and mapper write for the advancing cycle.
  always_comb begin
    w_next  = r_state;
    w_byte  = bus.cpu_ext_data_i;
    w_wr    = 1'b0;
    w_sel   = '0;
    w_wdata = '0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.exit_req & bus.ready) w_next = CS_FETCH;
      end
      CS_FETCH: begin
        w_byte = w_cs_byte;
        if (w_fetch_ok) w_next = CS_EX;
      end
      CS_EX: begin
        w_byte = w_cs_byte;
        if (bus.ready) w_next = PLP_FETCH;
      end
      PLP_FETCH: begin
        w_byte = OP_PLP;
        if (w_fetch_ok) begin
          w_next  = PLP_DEC;
          w_wr    = 1'b1;
          w_sel   = 2'd0;
          w_wdata = bus.saved_map_off0[7:0];
        end
      end
      PLP_DEC: begin
        w_byte = OP_PLP;
        if (bus.ready) begin
          w_next  = PLP_EX;
          w_wr    = 1'b1;
          w_sel   = 2'd1;
          w_wdata = {bus.saved_map_en[3:0], bus.saved_map_off0[11:8]};
        end
      end
      PLP_EX: begin
        w_byte = bus.saved_p;
        if (bus.ready) begin
          w_next  = JMP_FETCH;
          w_wr    = 1'b1;
          w_sel   = 2'd2;
          w_wdata = bus.saved_map_off1[7:0];
        end
      end
      JMP_FETCH: begin
        w_byte = OP_JMP;
        if (w_fetch_ok) begin
          w_next  = JMP_PCL;
          w_wr    = 1'b1;
          w_sel   = 2'd3;
          w_wdata = {bus.saved_map_en[7:4], bus.saved_map_off1[11:8]};
        end
      end
      JMP_PCL: begin
        w_byte = bus.saved_pc[7:0];
        if (bus.ready) w_next = JMP_PCH;
      end
      JMP_PCH: begin
        w_byte = bus.saved_pc[15:8];
        if (bus.ready) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
        w_byte = '0;
      end
    endcase
    // A reset cycle must not leak a write or completion strobe from the
    // state it is abandoning.
    if (reset) begin
      w_wr    = 1'b0;
      w_sel   = '0;
      w_wdata = '0;
      w_done  = 1'b0;
    end
  end

  assign bus.cpu_data_i    = w_byte;
  assign bus.inject_active = w_busy;
  assign bus.map_enable    = w_busy ? 1'b0 : bus.map_gate;
  assign bus.mapper_wr     = w_wr;
  assign bus.mapper_sel    = w_sel;
  assign bus.mapper_wdata  = w_wdata;
  assign bus.exit_done     = w_done;
  assign bus.busy          = w_busy;

endmodule

// File: tb/tb_hyper_exit_seq.sv
// Self-checking bench for hyper_exit_seq: directed scenarios plus a long
// randomized run, all compared against a stream-level reference model.
module tb_hyper_exit_seq;

  logic clk;
  logic reset;
  hyper_exit_seq_if bus();

  hyper_exit_seq #(
    .OP_CLE(8'h02),
    .OP_SEE(8'h03),
    .OP_PLP(8'h28),
    .OP_JMP(8'h4C)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned cyc      = 0;

  // Model: position in the 8-byte exit stream (0 = not sequencing).
  int          m_pos = 0;

  // Observation logs for directed scenarios.
  logic [7:0]  rec_byte[$];
  logic [1:0]  rec_sel[$];
  logic [7:0]  rec_wd[$];
  int unsigned done_cnt;
  int unsigned done_cyc;
  logic        obs_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // The synthetic instruction stream, byte n for stream position n (1..8).
  function automatic logic [7:0] stream_byte(input int p);
    logic [7:0] s[8];
    logic [7:0] e_op;
    e_op = bus.saved_p[5] ? 8'h03 : 8'h02;
    s = '{e_op, e_op, 8'h28, 8'h28, bus.saved_p, 8'h4C,
          bus.saved_pc[7:0], bus.saved_pc[15:8]};
    return s[p-1];
  endfunction

  // Guest MAP register images in write order A, X, Y, Z.
  function automatic logic [7:0] map_image(input int idx);
    logic [7:0] m[4];
    m = '{bus.saved_map_off0[7:0],
          {bus.saved_map_en[3:0], bus.saved_map_off0[11:8]},
          bus.saved_map_off1[7:0],
          {bus.saved_map_en[7:4], bus.saved_map_off1[11:8]}};
    return m[idx];
  endfunction

  // One clock: drive inputs, check all outputs against the model, advance.
  task automatic step(input logic rdy, input logic syn, input logic req, input logic rst);
    logic       fetch, adv, ew, edn;
    logic [7:0] eb, ed;
    logic [1:0] es;
    @(negedge clk);
    bus.ready          = rdy;
    bus.cpu_sync       = syn;
    bus.exit_req       = req;
    reset              = rst;
    bus.cpu_ext_data_i = 8'($urandom);
    bus.map_gate       = 1'($urandom);
    #1;
    fetch = (m_pos == 1) || (m_pos == 3) || (m_pos == 6);
    adv   = (m_pos != 0) && rdy && (!fetch || syn) && !rst;
    eb    = (m_pos == 0) ? bus.cpu_ext_data_i : stream_byte(m_pos);
    // Mapper writes ride on the advance out of stream positions 3..6.
    ew    = adv && (m_pos >= 3) && (m_pos <= 6);
    es    = ew ? 2'(m_pos - 3) : 2'd0;
    ed    = ew ? map_image(m_pos - 3) : 8'h00;
    edn   = adv && (m_pos == 8);
    check("cpu_data_i",    32'(bus.cpu_data_i),    32'(eb));
    check("inject_active", 32'(bus.inject_active), 32'(m_pos != 0));
    check("busy",          32'(bus.busy),          32'(m_pos != 0));
    check("map_enable",    32'(bus.map_enable),    32'((m_pos == 0) ? bus.map_gate : 1'b0));
    check("mapper_wr",     32'(bus.mapper_wr),     32'(ew));
    check("mapper_sel",    32'(bus.mapper_sel),    32'(es));
    check("mapper_wdata",  32'(bus.mapper_wdata),  32'(ed));
    check("exit_done",     32'(bus.exit_done),     32'(edn));
    obs_busy = bus.busy;
    if (adv) rec_byte.push_back(bus.cpu_data_i);
    if (bus.mapper_wr) begin
      rec_sel.push_back(bus.mapper_sel);
      rec_wd.push_back(bus.mapper_wdata);
    end
    if (bus.exit_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    if (rst)              m_pos = 0;
    else if (m_pos == 0)  m_pos = (req && rdy) ? 1 : 0;
    else if (adv)         m_pos = (m_pos == 8) ? 0 : m_pos + 1;
    cyc++;
  endtask

  task automatic clear_logs();
    rec_byte.delete();
    rec_sel.delete();
    rec_wd.delete();
    done_cnt = 0;
    done_cyc = 0;
    cyc      = 0;
  endtask

  task automatic set_basic(input logic [7:0] p);
    bus.saved_p        = p;
    bus.saved_pc       = 16'h1234;
    bus.saved_map_off0 = 12'h1AB;
    bus.saved_map_off1 = 12'h2CD;
    bus.saved_map_en   = 8'h5A;
  endtask

  task automatic check_basic_logs(input string tag, input logic [7:0] e_op);
    logic [7:0] eb[8];
    logic [7:0] ew[4];
    eb = '{e_op, e_op, 8'h28, 8'h28, 8'h24, 8'h4C, 8'h34, 8'h12};
    ew = '{8'hAB, 8'hA1, 8'hCD, 8'h52};
    eb[4] = bus.saved_p;
    check({tag, "_nbytes"}, rec_byte.size(), 8);
    for (int i = 0; i < 8 && i < rec_byte.size(); i++)
      check({tag, "_byte"}, 32'(rec_byte[i]), 32'(eb[i]));
    check({tag, "_nwrites"}, rec_sel.size(), 4);
    for (int i = 0; i < 4 && i < rec_sel.size(); i++) begin
      check({tag, "_wsel"},  32'(rec_sel[i]), i);
      check({tag, "_wdata"}, 32'(rec_wd[i]),  32'(ew[i]));
    end
    check({tag, "_ndone"}, done_cnt, 1);
  endtask

  initial begin
    int unsigned guard;
    int unsigned h1, h2, busy_cycles;
    bus.exit_req = 1'b0; bus.ready = 1'b0; bus.cpu_sync = 1'b0;
    bus.cpu_ext_data_i = '0; bus.map_gate = 1'b0;
    set_basic(8'h24);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, with a request during reset that must be ignored.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // IDLE passthrough over a few cycles with random map_gate.
    repeat (4) step(1'b1, 1'($urandom), 1'b0, 1'b0);

    // Basic exit, E=1, minimum latency.
    set_basic(8'h24);
    clear_logs();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) step(1'b1, (c == 1 || c == 3 || c == 6), 1'b0, 1'b0);
    check_basic_logs("basic", 8'h03);
    check("basic_done_cycle", done_cyc, 8);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("basic_idle_after", 32'(obs_busy), 0);

    // E clear.
    set_basic(8'h04);
    clear_logs();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) step(1'b1, (c == 1 || c == 3 || c == 6), 1'b0, 1'b0);
    check_basic_logs("eclr", 8'h02);
    check("eclr_done_cycle", done_cyc, 8);

    // Stalls: alternating ready plus a 5-cycle gap in PLP_DEC.
    set_basic(8'h24);
    clear_logs();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    h1 = 0;
    guard = 0;
    while (m_pos != 0 && guard < 100) begin
      if (m_pos == 4 && h1 < 5) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        h1++;
      end else begin
        step(guard[0], 1'b1, 1'b0, 1'b0);
      end
      guard++;
    end
    check("stall_timeout", 32'(guard < 100), 1);
    check_basic_logs("stall", 8'h03);

    // Late sync: 3 ready cycles with sync low in CS_FETCH and JMP_FETCH.
    clear_logs();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    h1 = 0; h2 = 0; busy_cycles = 0; guard = 0;
    while (m_pos != 0 && guard < 100) begin
      if (m_pos == 1 && h1 < 3) begin
        step(1'b1, 1'b0, 1'b0, 1'b0); h1++;
      end else if (m_pos == 6 && h2 < 3) begin
        step(1'b1, 1'b0, 1'b0, 1'b0); h2++;
      end else begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
      end
      if (obs_busy) busy_cycles++;
      guard++;
    end
    check("late_timeout", 32'(guard < 100), 1);
    check("late_duration", busy_cycles, 14);
    check_basic_logs("late", 8'h03);

    // Reset in JMP_PCL.
    clear_logs();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (m_pos != 7 && guard < 50) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("rst_reach_pcl", m_pos, 7);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_busy", 32'(obs_busy), 0);
    check("rst_nwrites", rec_sel.size(), 4);
    check("rst_ndone", done_cnt, 0);

    // exit_req held high while busy must not restart or double-complete.
    clear_logs();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ignreq_ndone", done_cnt, 1);
    check("ignreq_idle", 32'(obs_busy), 0);

    // Randomized run with random saved state, handshakes and resets.
    for (int n = 0; n < 3000; n++) begin
      if (m_pos == 0 && ($urandom_range(0, 3) == 0)) begin
        bus.saved_p        = 8'($urandom);
        bus.saved_pc       = 16'($urandom);
        bus.saved_map_off0 = 12'($urandom);
        bus.saved_map_off1 = 12'($urandom);
        bus.saved_map_en   = 8'($urandom);
      end
      step(($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
